// File: rtl/fifo_demo_pkg.sv
// Shared types and constants for the FIFO burst reader and its sequence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_demo_pkg;

  // Burst-reader FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_READ  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // FIFO read latency (rd_en -> rdata); the reader is built around one cycle
  localparam int RD_LAT_DEF = 1;

  // 8-bit counter increment that sticks at all-ones
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_seq_check.sv
// Checks that read data forms an incrementing sequence; counts words and mismatches.
// Latency: seq_err/err_cnt/word_cnt update one cycle after the rd_vld cycle.
// Backpressure: none, consumes every rd_vld word.
module fifo_seq_check
  import fifo_demo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_vld_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              seq_err_o,
  output logic [7:0]        err_cnt_o,
  output logic [15:0]       word_cnt_o
);

  logic [DATA_W-1:0] exp_q, exp_d;
  logic              seq_err_q, seq_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              mismatch;

  // Compare each valid word with the expected value; always resync exp to data+1
  always_comb begin
    exp_d      = exp_q;
    seq_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    mismatch   = (rdata_i != exp_q);
    if (rd_vld_i) begin
      exp_d      = rdata_i + 1'b1;
      word_cnt_d = word_cnt_q + 16'd1;
      if (mismatch) begin
        seq_err_d = 1'b1;
        err_cnt_d = sat_inc8(err_cnt_q);
      end
    end
  end

  // Checker state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q      <= '0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      exp_q      <= exp_d;
      seq_err_q  <= seq_err_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign seq_err_o  = seq_err_q;
  assign err_cnt_o  = err_cnt_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Waits START_DLY cycles after almost_full, then drains the FIFO in one burst and checks the data sequence.
// Latency: first read START_DLY+1 cycles after almost_full is sampled; check result one cycle after data.
// Backpressure: never reads while empty; a burst ends when the FIFO runs dry.
module fifo_burst_reader
  import fifo_demo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int START_DLY = 10,
  parameter int RD_LAT    = RD_LAT_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              almost_full,
  input  logic              almost_empty,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  output logic              rd_busy,
  output logic              seq_err,
  output logic [7:0]        err_cnt,
  output logic [15:0]       word_cnt
);

  localparam int              CNT_W    = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(START_DLY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [RD_LAT-1:0] rd_vld_q;
  logic              rd_vld;

  // Next state, delay count and read strobe; almost_full only matters in IDLE
  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = '0;
    fifo_rd_en = 1'b0;
    rd_busy    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        rd_busy = 1'b0;
        if (almost_full) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        if (dly_cnt_q == DLY_LAST) state_d = ST_READ;
        else                       dly_cnt_d = dly_cnt_q + 1'b1;
      end
      ST_READ: begin
        fifo_rd_en = !empty;
        // stop once the last word is popped, or as soon as the FIFO is seen empty
        if (empty || (fifo_rd_en && almost_empty)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // one cycle for the final popped word to arrive and be checked
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and delay counter registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      dly_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
    end
  end

  // Track which cycles carry valid read data
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_vld_q <= '0;
    end else begin
      rd_vld_q[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LAT; i++) rd_vld_q[i] <= rd_vld_q[i-1];
    end
  end

  assign rd_vld = rd_vld_q[RD_LAT-1];

  fifo_seq_check #(
    .DATA_W (DATA_W)
  ) u_seq_check (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .rd_vld_i   (rd_vld),
    .rdata_i    (fifo_rdata),
    .seq_err_o  (seq_err),
    .err_cnt_o  (err_cnt),
    .word_cnt_o (word_cnt)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench: behavioural FIFO model, table of drain bursts, plus hand sequences for
// empty mid-burst and reset mid-burst.
module tb_fifo_burst_reader;

  logic        sys_clk     = 1'b0;
  logic        sys_rst_n   = 1'b1;
  logic        almost_full = 1'b0;
  logic        force_empty = 1'b0;
  logic        almost_empty, empty;
  logic [7:0]  fifo_rdata  = 8'h00;
  logic        fifo_rd_en, rd_busy, seq_err;
  logic [7:0]  err_cnt;
  logic [15:0] word_cnt;

  // FIFO model storage
  logic [7:0] mem [0:511];
  logic [8:0] wr_ptr = 9'd0;
  logic [8:0] rd_ptr = 9'd0;
  logic [8:0] fill_lvl;

  int n_cmp  = 0;
  int n_fail = 0;

  // monitor counters (only ever incremented; tests use deltas)
  int rd_pulses  = 0;
  int err_pulses = 0;
  int underflows = 0;
  int last_err_wc = -1;

  typedef struct {
    bit         do_rst;
    logic [7:0] start;
    int         len;
    int         jump_at;     // index from which data skips ahead by 2 (-1: none)
    bit         konst;       // every word equals start
    int         exp_err;
    int         exp_wc;
    int         exp_pulses;
    int         exp_err_wc;  // word_cnt seen at the last seq_err (-1: not checked)
  } vec_t;

  vec_t vecs [4];

  fifo_burst_reader #(
    .DATA_W    (8),
    .START_DLY (10),
    .RD_LAT    (1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .empty        (empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_rd_en   (fifo_rd_en),
    .rd_busy      (rd_busy),
    .seq_err      (seq_err),
    .err_cnt      (err_cnt),
    .word_cnt     (word_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  assign fill_lvl     = wr_ptr - rd_ptr;
  assign empty        = force_empty || (fill_lvl == 9'd0);
  assign almost_empty = force_empty || (fill_lvl <= 9'd1);

  // one-cycle read latency FIFO
  always @(posedge sys_clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 9'd1;
    end
  end

  // monitor, sampled 2 time units after the falling edge
  always @(negedge sys_clk) begin
    #2;
    if (fifo_rd_en) rd_pulses++;
    if (fifo_rd_en && empty) underflows++;
    if (seq_err) begin
      err_pulses++;
      last_err_wc = int'(word_cnt);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 9'd1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    wr_ptr    = rd_ptr;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // raise almost_full for one cycle, count busy cycles before the first read
  task automatic start_burst(output int idle, output bit got);
    @(negedge sys_clk);
    almost_full = 1'b1;
    idle = 0;
    got  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge sys_clk);
      almost_full = 1'b0;
      #1;
      if (fifo_rd_en) begin
        got = 1'b1;
        break;
      end
      if (rd_busy) idle++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  idle, r0, e0, u0;
    bit  got, done;
    logic [7:0] val;
    if (v.do_rst) do_reset();
    for (int i = 0; i < v.len; i++) begin
      val = v.konst ? v.start
                    : 8'(int'(v.start) + i + ((v.jump_at >= 0 && i >= v.jump_at) ? 2 : 0));
      push(val);
    end
    r0 = rd_pulses;
    e0 = err_pulses;
    u0 = underflows;
    start_burst(idle, got);
    chk({tag, " first_read_seen"}, int'(got), 1);
    chk({tag, " idle_cycles"}, idle, 10);
    done = 1'b0;
    for (int c = 0; c < v.len + 50; c++) begin
      @(negedge sys_clk);
      #1;
      if (!rd_busy) begin
        done = 1'b1;
        break;
      end
    end
    #2;
    chk({tag, " burst_done"}, int'(done), 1);
    chk({tag, " reads"}, rd_pulses - r0, v.len);
    chk({tag, " underflow"}, underflows - u0, 0);
    chk({tag, " err_cnt"}, int'(err_cnt), v.exp_err);
    chk({tag, " word_cnt"}, int'(word_cnt), v.exp_wc);
    chk({tag, " seq_err_pulses"}, err_pulses - e0, v.exp_pulses);
    if (v.exp_err_wc >= 0) chk({tag, " err_position"}, last_err_wc, v.exp_err_wc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idle, r0, u0, wc0;
    bit  got;
    vec_t tail;

    //        rst  start  len  jump  konst err  wc   pulses err_wc
    vecs[0] = '{1'b1, 8'h00, 254, -1, 1'b0,   0, 254,   0,  -1};
    vecs[1] = '{1'b0, 8'hFE,   4, -1, 1'b0,   0, 258,   0,  -1};
    vecs[2] = '{1'b1, 8'h00,   9,  7, 1'b0,   1,   9,   1,   8};
    vecs[3] = '{1'b1, 8'h55, 300, -1, 1'b1, 255, 300, 300, 300};

    // asynchronous reset before any clock edge
    #1 sys_rst_n = 1'b0;
    #1;
    chk("rst fifo_rd_en", int'(fifo_rd_en), 0);
    chk("rst rd_busy", int'(rd_busy), 0);
    chk("rst seq_err", int'(seq_err), 0);
    chk("rst err_cnt", int'(err_cnt), 0);
    chk("rst word_cnt", int'(word_cnt), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    for (int k = 0; k < 4; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // empty asserted mid-READ
    do_reset();
    for (int i = 0; i < 20; i++) push(8'(i));
    r0 = rd_pulses;
    u0 = underflows;
    start_burst(idle, got);
    chk("emp first_read_seen", int'(got), 1);
    @(negedge sys_clk);
    @(negedge sys_clk);
    force_empty = 1'b1;
    #1;
    chk("emp rd_en_drops", int'(fifo_rd_en), 0);
    chk("emp busy_read", int'(rd_busy), 1);
    @(negedge sys_clk);
    #1;
    chk("emp busy_flush", int'(rd_busy), 1);
    chk("emp rd_en_flush", int'(fifo_rd_en), 0);
    @(negedge sys_clk);
    #1;
    chk("emp busy_idle", int'(rd_busy), 0);
    #2;
    chk("emp reads", rd_pulses - r0, 2);
    chk("emp underflow", underflows - u0, 0);
    chk("emp word_cnt", int'(word_cnt), 2);
    chk("emp err_cnt", int'(err_cnt), 0);
    wr_ptr      = rd_ptr;
    force_empty = 1'b0;

    // reset pulse during READ
    do_reset();
    for (int i = 0; i < 20; i++) push(8'(i));
    start_burst(idle, got);
    chk("rstrd first_read_seen", int'(got), 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("rstrd rd_en", int'(fifo_rd_en), 0);
    chk("rstrd busy", int'(rd_busy), 0);
    chk("rstrd word_cnt", int'(word_cnt), 0);
    chk("rstrd err_cnt", int'(err_cnt), 0);
    chk("rstrd seq_err", int'(seq_err), 0);
    r0 = rd_pulses;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (15) @(negedge sys_clk);
    #3;
    chk("rstrd no_reads_after", rd_pulses - r0, 0);
    chk("rstrd idle_after", int'(rd_busy), 0);
    chk("rstrd word_cnt_after", int'(word_cnt), 0);
    wr_ptr = rd_ptr;

    // after reset the first datum is checked against 0
    wc0  = int'(word_cnt);
    tail = '{1'b0, 8'h00, 3, -1, 1'b0, 0, 3, 0, -1};
    run_vec(tail, "post_rst");
    chk("post_rst wc_base", wc0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
